// File: rtl/stream_demux4_v1.sv
`default_nettype none
// ============================================================================
//  Module   : stream_demux4_v1
//  Purpose  : 1-to-4 valid/ready stream demultiplexer. Each output has a
//             one-entry registered stage. The destination is locked per
//             packet: it is taken from in_sel on the first beat and held
//             until the beat that carries in_last.
//  Options  : STREAM_DEMUX_STATS_EN adds four 16-bit per-output counters of
//             completed packets (pkt_cnt1..pkt_cnt4).
//  Revision : 1.0  initial release
// ============================================================================
module stream_demux4_v1 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic [1:0]       in_sel,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [3:0]       out_last,
  output logic [WIDTH-1:0] out1_data,
  output logic [WIDTH-1:0] out2_data,
  output logic [WIDTH-1:0] out3_data,
  output logic [WIDTH-1:0] out4_data,
  output logic             busy
`ifdef STREAM_DEMUX_STATS_EN
  ,
  output logic [15:0]      pkt_cnt1,
  output logic [15:0]      pkt_cnt2,
  output logic [15:0]      pkt_cnt3,
  output logic [15:0]      pkt_cnt4
`endif
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t           state;
  logic [1:0]       lock_sel;
  logic [1:0]       route_sel;
  logic             accept;
  logic [3:0]       load;
  logic [3:0]       slot_valid;
  logic [3:0]       slot_last;
  logic [WIDTH-1:0] slot_data [4];

  // Mid-packet beats follow the locked destination; in_sel only matters in IDLE.
  assign route_sel = (state == ST_LOCKED) ? lock_sel : in_sel;

  // Ready when the routed slot is empty or is draining this cycle.
  assign in_ready = !slot_valid[route_sel] || out_ready[route_sel];
  assign accept   = in_valid && in_ready;
  assign load     = accept ? (4'b0001 << route_sel) : 4'b0000;

  // Packet framing FSM: lock the destination on a non-last first beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      lock_sel <= 2'd0;
      busy     <= 1'b0;
    end else if (accept) begin
      case (state)
        ST_IDLE: begin
          if (!in_last) begin
            state    <= ST_LOCKED;
            lock_sel <= in_sel;
            busy     <= 1'b1;
          end
        end
        ST_LOCKED: begin
          if (in_last) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Output slots: a load takes priority over a drain; a drain keeps the payload.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_valid <= 4'b0000;
      slot_last  <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        slot_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (load[i]) begin
          slot_valid[i] <= 1'b1;
          slot_last[i]  <= in_last;
          slot_data[i]  <= in_data;
        end else if (out_ready[i]) begin
          slot_valid[i] <= 1'b0;
        end
      end
    end
  end

  assign out_valid = slot_valid;
  assign out_last  = slot_last;
  assign out1_data = slot_data[0];
  assign out2_data = slot_data[1];
  assign out3_data = slot_data[2];
  assign out4_data = slot_data[3];

`ifdef STREAM_DEMUX_STATS_EN
  logic [15:0] pkt_cnt [4];

  // Count completed packets per output (last-beat handshakes), wrapping at 16 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        pkt_cnt[i] <= 16'd0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (slot_valid[i] && out_ready[i] && slot_last[i]) begin
          pkt_cnt[i] <= pkt_cnt[i] + 16'd1;
        end
      end
    end
  end

  assign pkt_cnt1 = pkt_cnt[0];
  assign pkt_cnt2 = pkt_cnt[1];
  assign pkt_cnt3 = pkt_cnt[2];
  assign pkt_cnt4 = pkt_cnt[3];
`endif

endmodule
`default_nettype wire

// File: tb/tb_stream_demux4_v1.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stream_demux4_v1
//  Purpose  : Directed, table-driven bench for stream_demux4_v1 with
//             hand-written sequences for throughput and mid-packet reset.
//  Revision : 1.0  initial release
// ============================================================================
module tb_stream_demux4_v1;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic [1:0]  in_sel;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [3:0]  out_last;
  logic [31:0] out1_data;
  logic [31:0] out2_data;
  logic [31:0] out3_data;
  logic [31:0] out4_data;
  logic        busy;
`ifdef STREAM_DEMUX_STATS_EN
  logic [15:0] pkt_cnt1;
  logic [15:0] pkt_cnt2;
  logic [15:0] pkt_cnt3;
  logic [15:0] pkt_cnt4;
`endif

  stream_demux4_v1 #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .out1_data (out1_data),
    .out2_data (out2_data),
    .out3_data (out3_data),
    .out4_data (out4_data),
    .busy      (busy)
`ifdef STREAM_DEMUX_STATS_EN
    ,
    .pkt_cnt1  (pkt_cnt1),
    .pkt_cnt2  (pkt_cnt2),
    .pkt_cnt3  (pkt_cnt3),
    .pkt_cnt4  (pkt_cnt4)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [1:0]  sel;
    logic [31:0] data;
    logic        last;
    logic [3:0]  ordy;
    logic        e_rdy;
    logic [3:0]  e_valid;
    logic [3:0]  e_last;
    logic        e_busy;
    int          port;
    logic [31:0] e_data;
  } vec_t;

  vec_t vecs [10];
  int   passed;
  int   total;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] port_data(input int p);
    case (p)
      0: return out1_data;
      1: return out2_data;
      2: return out3_data;
      default: return out4_data;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] sel, input logic [31:0] d,
                       input logic l, input logic [3:0] ordy);
    in_valid  = v;
    in_sel    = sel;
    in_data   = d;
    in_last   = l;
    out_ready = ordy;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst    = 1'b1;
    drive(1'b0, 2'd0, 32'h0, 1'b0, 4'b0000);

    // Single beat, packet lock (out4 must stay idle), idle drain, back-pressure.
    vecs[0] = '{1'b1, 2'd2, 32'hDEADBEEF, 1'b1, 4'b1111, 1'b1, 4'b0100, 4'b0100, 1'b0, 2, 32'hDEADBEEF};
    vecs[1] = '{1'b1, 2'd1, 32'h000000A1, 1'b0, 4'b1111, 1'b1, 4'b0010, 4'b0100, 1'b1, 1, 32'h000000A1};
    vecs[2] = '{1'b1, 2'd3, 32'h000000A2, 1'b0, 4'b1111, 1'b1, 4'b0010, 4'b0100, 1'b1, 1, 32'h000000A2};
    vecs[3] = '{1'b1, 2'd3, 32'h000000A3, 1'b1, 4'b1111, 1'b1, 4'b0010, 4'b0110, 1'b0, 1, 32'h000000A3};
    vecs[4] = '{1'b0, 2'd0, 32'h00000000, 1'b0, 4'b1111, 1'b1, 4'b0000, 4'b0110, 1'b0, 1, 32'h000000A3};
    vecs[5] = '{1'b1, 2'd0, 32'h000000B0, 1'b1, 4'b0000, 1'b1, 4'b0001, 4'b0111, 1'b0, 0, 32'h000000B0};
    vecs[6] = '{1'b1, 2'd0, 32'h000000B1, 1'b1, 4'b0000, 1'b0, 4'b0001, 4'b0111, 1'b0, 0, 32'h000000B0};
    vecs[7] = '{1'b1, 2'd1, 32'h000000C0, 1'b1, 4'b0000, 1'b1, 4'b0011, 4'b0111, 1'b0, 1, 32'h000000C0};
    vecs[8] = '{1'b1, 2'd0, 32'h000000B1, 1'b1, 4'b0001, 1'b1, 4'b0011, 4'b0111, 1'b0, 0, 32'h000000B1};
    vecs[9] = '{1'b0, 2'd0, 32'h00000000, 1'b0, 4'b0011, 1'b1, 4'b0000, 4'b0111, 1'b0, 0, 32'h000000B1};

    // Reset state
    step();
    step();
    rst = 1'b0;
    check("reset_out_valid", 64'(out_valid), 64'h0);
    check("reset_out_last",  64'(out_last),  64'h0);
    check("reset_busy",      64'(busy),      64'h0);
    check("reset_in_ready",  64'(in_ready),  64'h1);
    for (int p = 0; p < 4; p++) check("reset_data", 64'(port_data(p)), 64'h0);

    // Table-driven vectors
    for (int k = 0; k < 10; k++) begin
      drive(vecs[k].v, vecs[k].sel, vecs[k].data, vecs[k].last, vecs[k].ordy);
      #1;
      check($sformatf("v%0d_in_ready", k), 64'(in_ready), 64'(vecs[k].e_rdy));
      step();
      check($sformatf("v%0d_out_valid", k), 64'(out_valid), 64'(vecs[k].e_valid));
      check($sformatf("v%0d_out_last", k),  64'(out_last),  64'(vecs[k].e_last));
      check($sformatf("v%0d_busy", k),      64'(busy),      64'(vecs[k].e_busy));
      check($sformatf("v%0d_data", k),      64'(port_data(vecs[k].port)), 64'(vecs[k].e_data));
    end

    // Full throughput: 8-beat packet to port 3, out_ready[3] held high
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 2'd3, 32'h7000_0000 + 32'(k), (k == 7), 4'b1000);
      #1;
      check($sformatf("thru%0d_in_ready", k), 64'(in_ready), 64'h1);
      step();
      check($sformatf("thru%0d_valid", k), 64'(out_valid), 64'h8);
      check($sformatf("thru%0d_data", k),  64'(out4_data), 64'h7000_0000 + 64'(k));
    end
    check("thru_busy_end", 64'(busy), 64'h0);
    drive(1'b0, 2'd0, 32'h0, 1'b0, 4'b1000);
    step();
    check("thru_drained", 64'(out_valid), 64'h0);

    // Reset mid-packet: two beats of a 4-beat packet to port 0, then reset
    drive(1'b1, 2'd0, 32'h000000D0, 1'b0, 4'b0001);
    step();
    drive(1'b1, 2'd2, 32'h000000D1, 1'b0, 4'b0001);
    step();
    check("mid_busy", 64'(busy), 64'h1);
    rst = 1'b1;
    drive(1'b0, 2'd0, 32'h0, 1'b0, 4'b0000);
    step();
    rst = 1'b0;
    check("mid_rst_valid", 64'(out_valid), 64'h0);
    check("mid_rst_busy",  64'(busy),      64'h0);
    check("mid_rst_data1", 64'(out1_data), 64'h0);
    drive(1'b1, 2'd1, 32'h000000E0, 1'b1, 4'b1111);
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'h1);
    step();
    check("post_rst_valid", 64'(out_valid), 64'h2);
    check("post_rst_data",  64'(out2_data), 64'hE0);
    check("post_rst_busy",  64'(busy),      64'h0);
    drive(1'b0, 2'd0, 32'h0, 1'b0, 4'b1111);
    step();
    check("post_rst_drain", 64'(out_valid), 64'h0);
`ifdef STREAM_DEMUX_STATS_EN
    check("pkt_cnt2", 64'(pkt_cnt2), 64'h1);
    check("pkt_cnt1", 64'(pkt_cnt1), 64'h0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
